// File: rtl/img2col_streamer.sv
// img2col_streamer: accepts a raster-order pixel stream and emits every KxK
// window (step STRIDE) as a flat K*K vector, tagged with its window row and
// column index. A (K-1)-row line buffer plus a KxK shift window produce a new
// window one cycle after the pixel that completes it is accepted.
//
// Handshake: both streams are valid/ready. A transfer happens on a rising
// edge where valid && ready. A producer holding valid keeps its payload
// stable until the transfer. in_ready depends combinationally on out_ready:
// input is accepted only when the output register is free or being drained.
module img2col_streamer #(
   parameter int DATA_W = 16,
   parameter int IMG_W  = 28,
   parameter int IMG_H  = 28,
   parameter int K      = 5,
   parameter int STRIDE = 1
) (
   input  logic              clk,
   input  logic              nrst,
   input  logic              start,
   input  logic              in_valid,
   input  logic [DATA_W-1:0] in_data,
   output logic              in_ready,
   output logic [DATA_W-1:0] out [K*K],
   output logic              out_valid,
   input  logic              out_ready,
   output logic [5:0]        row_num,
   output logic [5:0]        col_num,
   output logic              map_finish,
   output logic [1:0]        dbg_state
);

   localparam int KK = K * K;
   localparam int OH = (IMG_H - K) / STRIDE + 1;
   localparam int OW = (IMG_W - K) / STRIDE + 1;
   localparam int CW = $clog2(IMG_W);

   localparam logic [5:0] LP_KM1  = 6'(K - 1);
   localparam logic [5:0] LP_WM1  = 6'(IMG_W - 1);
   localparam logic [5:0] LP_HM1  = 6'(IMG_H - 1);
   localparam logic [5:0] LP_OHM1 = 6'(OH - 1);
   localparam logic [5:0] LP_OWM1 = 6'(OW - 1);

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_FLUSH, S_DONE} state_t;

   state_t r_state;
   state_t w_state_nxt;

   // Pixel position (r,c) of the next pixel to arrive, and the (R,C) index
   // the next completed window will carry.
   logic [5:0] r_pr;
   logic [5:0] r_pc;
   logic [5:0] r_wr;
   logic [5:0] r_wc;
   // Set once the final window has been handed off, so FLUSH cannot wait
   // forever when the last pixel completes no window.
   logic       r_last_hs;

   logic              r_out_valid;
   logic [5:0]        r_row_num;
   logic [5:0]        r_col_num;
   logic [DATA_W-1:0] r_out [KK];

   // Row 0 of the line buffer is the oldest row (r-K+1); row K-2 is r-1.
   logic [DATA_W-1:0] r_lb  [K-1][IMG_W];
   logic [DATA_W-1:0] r_win [K][K];

   logic [CW-1:0]     w_pc_idx;
   logic [DATA_W-1:0] w_col [K];
   logic [DATA_W-1:0] w_win_nxt [K][K];
   logic              w_accept;
   logic              w_hs;
   logic              w_r_ok;
   logic              w_c_ok;
   logic              w_complete;
   logic              w_last_pix;
   logic              w_last_hs;

   assign w_pc_idx   = r_pc[CW-1:0];
   assign w_accept   = in_valid && in_ready;
   assign w_hs       = r_out_valid && out_ready;
   // STRIDE is 1 or 2, so the stride alignment test reduces to a parity match.
   assign w_r_ok     = (r_pr >= LP_KM1) && ((STRIDE == 1) || (r_pr[0] == LP_KM1[0]));
   assign w_c_ok     = (r_pc >= LP_KM1) && ((STRIDE == 1) || (r_pc[0] == LP_KM1[0]));
   assign w_complete = w_accept && w_r_ok && w_c_ok;
   assign w_last_pix = (r_pr == LP_HM1) && (r_pc == LP_WM1);
   assign w_last_hs  = w_hs && (r_row_num == LP_OHM1) && (r_col_num == LP_OWM1);

   assign out       = r_out;
   assign out_valid = r_out_valid;
   assign row_num   = r_row_num;
   assign col_num   = r_col_num;
   assign dbg_state = r_state;

   // Column entering the window: K-1 buffered rows above plus the new pixel.
   always_comb begin
      for (int i = 0; i < K - 1; i++) begin
         w_col[i] = r_lb[i][w_pc_idx];
      end
      w_col[K-1] = in_data;
   end

   // Window after shifting left by one column and appending w_col.
   always_comb begin
      for (int i = 0; i < K; i++) begin
         for (int j = 0; j < K - 1; j++) begin
            w_win_nxt[i][j] = r_win[i][j+1];
         end
         w_win_nxt[i][K-1] = w_col[i];
      end
   end

   // FSM state register.
   always_ff @(posedge clk or posedge nrst) begin
      if (nrst) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // FSM next state, input ready and frame-complete pulse.
   always_comb begin
      w_state_nxt = r_state;
      in_ready    = 1'b0;
      map_finish  = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (start) w_state_nxt = S_RUN;
         end
         S_RUN: begin
            in_ready = !(r_out_valid && !out_ready);
            if (in_valid && in_ready && w_last_pix) w_state_nxt = S_FLUSH;
         end
         S_FLUSH: begin
            if (w_last_hs || r_last_hs) w_state_nxt = S_DONE;
         end
         S_DONE: begin
            map_finish  = 1'b1;
            w_state_nxt = S_IDLE;
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // Pixel and window position counters; cleared by a start in IDLE.
   always_ff @(posedge clk or posedge nrst) begin
      if (nrst) begin
         r_pr      <= '0;
         r_pc      <= '0;
         r_wr      <= '0;
         r_wc      <= '0;
         r_last_hs <= 1'b0;
      end else if (r_state == S_IDLE) begin
         if (start) begin
            r_pr      <= '0;
            r_pc      <= '0;
            r_wr      <= '0;
            r_wc      <= '0;
            r_last_hs <= 1'b0;
         end
      end else begin
         if (w_accept) begin
            if (r_pc == LP_WM1) begin
               r_pc <= '0;
               r_pr <= r_pr + 6'd1;
            end else begin
               r_pc <= r_pc + 6'd1;
            end
         end
         if (w_complete) begin
            if (r_wc == LP_OWM1) begin
               r_wc <= '0;
               r_wr <= r_wr + 6'd1;
            end else begin
               r_wc <= r_wc + 6'd1;
            end
         end
         if (w_last_hs) r_last_hs <= 1'b1;
      end
   end

   // Output register: load on completion, drop valid on a plain handshake.
   always_ff @(posedge clk or posedge nrst) begin
      if (nrst) begin
         r_out_valid <= 1'b0;
         r_row_num   <= '0;
         r_col_num   <= '0;
         for (int i = 0; i < KK; i++) begin
            r_out[i] <= '0;
         end
      end else if (w_complete) begin
         r_out_valid <= 1'b1;
         r_row_num   <= r_wr;
         r_col_num   <= r_wc;
         for (int i = 0; i < K; i++) begin
            for (int j = 0; j < K; j++) begin
               r_out[i*K+j] <= w_win_nxt[i][j];
            end
         end
      end else if (w_hs) begin
         r_out_valid <= 1'b0;
      end
   end

   // Line buffer and window shift on every accepted pixel; contents need no
   // reset because a window is only emitted after K fresh columns arrive.
   always_ff @(posedge clk) begin
      if (w_accept) begin
         for (int i = 0; i < K - 2; i++) begin
            r_lb[i][w_pc_idx] <= r_lb[i+1][w_pc_idx];
         end
         r_lb[K-2][w_pc_idx] <= in_data;
         for (int i = 0; i < K; i++) begin
            for (int j = 0; j < K; j++) begin
               r_win[i][j] <= w_win_nxt[i][j];
            end
         end
      end
   end

endmodule

// File: doc/img2col_streamer.md
IMG2COL_STREAMER -- requirements
Module: img2col_streamer

Interface
REQ-001 SHALL have parameter DATA_W, default 16, pixel width in bits.
REQ-002 SHALL have parameter IMG_W, default 28, image width in pixels (K..64).
REQ-003 SHALL have parameter IMG_H, default 28, image height in pixels (K..64).
REQ-004 SHALL have parameter K, default 5, square kernel size (2..7); window size is KK = K*K.
REQ-005 SHALL have parameter STRIDE, default 1, window step (1 or 2), applied to both rows and columns.
REQ-006 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-007 SHALL have port nrst, input, 1, asynchronous active-high reset (1 = reset).
REQ-008 SHALL have port start, input, 1, frame start request.
REQ-009 SHALL have port in_valid, input, 1, in_data valid.
REQ-010 SHALL have port in_data, input, DATA_W, pixel in raster order (row-major, row 0 first).
REQ-011 SHALL have port in_ready, output, 1, pixel accepted when in_valid && in_ready.
REQ-012 SHALL have port out, output, DATA_W x KK unpacked array, window element i*K+j = pixel(R*STRIDE+i, C*STRIDE+j).
REQ-013 SHALL have port out_valid, output, 1, window valid.
REQ-014 SHALL have port out_ready, input, 1, window consumed when out_valid && out_ready.
REQ-015 SHALL have ports row_num and col_num, output, 6 each, output-window indices R and C of the window on out.
REQ-016 SHALL have port map_finish, output, 1, one-cycle frame-complete pulse.

Function
REQ-017 SHALL implement FSM IDLE, RUN, FLUSH, DONE; reset state IDLE.
REQ-018 In IDLE, in_ready SHALL be 0; start=1 SHALL move to RUN and clear pixel counters (r,c) and window counters (R,C).
REQ-019 In RUN, in_ready SHALL equal !(out_valid && !out_ready).
REQ-020 Each accepted pixel SHALL be written to a (K-1)-row line buffer and a KxK window register; (r,c) SHALL advance raster-wise, c wrapping at IMG_W-1 to 0 with r+1.
REQ-021 A pixel at (r,c) SHALL complete a window when r>=K-1, c>=K-1, (r-K+1)%STRIDE==0 and (c-K+1)%STRIDE==0.
REQ-022 A completed window SHALL be presented on out with out_valid=1 in the cycle after the completing pixel is accepted (latency 1).
REQ-023 out, row_num, col_num SHALL hold stable while out_valid && !out_ready.
REQ-024 A handshake with no new window completing SHALL clear out_valid next cycle; a simultaneous handshake and completion SHALL keep out_valid=1 with the new window.
REQ-025 Windows SHALL be emitted in order R=0..OH-1, C=0..OW-1, OH=(IMG_H-K)/STRIDE+1, OW=(IMG_W-K)/STRIDE+1.
REQ-026 Accepting pixel (IMG_H-1, IMG_W-1) SHALL move to FLUSH with in_ready=0.
REQ-027 FLUSH SHALL move to DONE on the handshake of the last window (R=OH-1, C=OW-1).
REQ-028 DONE SHALL last one cycle with map_finish=1, then go to IDLE; map_finish SHALL be 0 in all other states.
REQ-029 start SHALL be ignored outside IDLE.
REQ-030 Pixels not covered by any window (stride 2, odd remainder) SHALL be accepted and discarded.

Reset
REQ-031 nrst=1 SHALL immediately force IDLE, in_ready=0, out_valid=0, map_finish=0, row_num=0, col_num=0, out all zero, and all counters to 0, regardless of clock.
REQ-032 Reset during RUN or FLUSH SHALL abandon the frame; the next frame requires a new start.

Verification
REQ-033 IMG_W=IMG_H=5, K=3, STRIDE=1, pixel value r*5+c -> first out_valid the cycle after pixel 12, out={0,1,2,5,6,7,10,11,12}; 9 windows total; map_finish one cycle after the last handshake.
REQ-034 Same image, STRIDE=2 -> 4 windows; window (R=0,C=1) out={2,3,4,7,8,9,12,13,14}; pixels outside windows not emitted.
REQ-035 out_ready held 0 for 10 cycles on the first window -> in_ready=0, out/row_num/col_num unchanged, no pixel lost after release.
REQ-036 nrst pulse mid-frame after 7 pixels -> IDLE, out_valid=0; new start and full frame -> identical results to REQ-033.
REQ-037 Defaults (28x28, K=5, STRIDE=1), out_ready always 1 -> exactly 576 windows, last row_num=23, col_num=23, one map_finish pulse.
REQ-038 start pulsed during RUN -> no counter change, frame completes normally.
